decoder_ctrl: RTL

DECODER_CTRL -- requirements
Module: decoder_ctrl

---
 rtl/decoder_ctrl_pkg.sv | 27 ++
 rtl/decoder_ctrl_llr_loader.sv | 42 ++++
 rtl/decoder_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decoder_ctrl_pkg.sv
// Shared types and constants for the min-sum decoder controller.
// State encoding and beat-count helpers used by the loader and the FSM.
package decoder_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VAR,
    CHK,
    OUT,
    DONE
  } state_t;

  localparam int N_V_DEF   = 44;
  localparam int LANES_DEF = 4;
  localparam int BEATS     = N_V_DEF / LANES_DEF;

  function automatic int beats_of(input int n_v, input int lanes);
    return n_v / lanes;
  endfunction

  // Counter width that stays legal for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decoder_ctrl_llr_loader.sv
// LLR beat assembler: packs LANES-wide beats into the full channel vector.
// A load while first is high always lands in beat 0.
module llr_loader
  import decoder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_V   = 44,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   first,
  input  logic [LANES*WIDTH-1:0] in_llr,
  output logic [WIDTH*N_V-1:0]   all_llrs,
  output logic                   last
);

  localparam int NB = beats_of(N_V, LANES);
  localparam int BW = cnt_w(NB);
  localparam int BEAT_W = LANES * WIDTH;

  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] idx;

  assign idx  = first ? '0 : beat_cnt;
  assign last = (idx == BW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      all_llrs <= '0;
    end else if (load) begin
      for (int b = 0; b < NB; b++) begin
        if (idx == BW'(b))
          all_llrs[b*BEAT_W +: BEAT_W] <= in_llr;
      end
      beat_cnt <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_ctrl.sv
// Layered min-sum decoder controller: loads LLR beats, sequences
// variable/check layers for N_ITER iterations, then the output layer.
module decoder_ctrl
  import decoder_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_V    = 44,
  parameter int N_C    = 12,
  parameter int LANES  = 4,
  parameter int N_ITER = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_llr,
  output logic [WIDTH*N_V-1:0]   all_llrs,
  output logic                   layer_start,
  output logic                   layer_sel,
  output logic                   first_iter,
  input  logic                   layer_done,
  output logic                   out_start,
  input  logic                   out_done,
  input  logic [N_V-N_C-1:0]     dw_in,
  output logic [N_V-N_C-1:0]     dw_out,
  output logic                   dw_valid,
  input  logic                   dw_ack,
  output logic                   busy
);

  localparam int IW = cnt_w(N_ITER);
  localparam int DW = N_V - N_C;

  state_t          state, state_nx;
  logic [IW-1:0]   iter_cnt, iter_nx;
  logic            ls_nx, os_nx, dv_nx;
  logic [DW-1:0]   dw_nx;
  logic            xfer, last;

  assign in_ready   = (state == IDLE) || (state == LOAD);
  assign xfer       = in_valid && in_ready;
  assign layer_sel  = (state == CHK);
  assign first_iter = ((state == VAR) || (state == CHK)) && (iter_cnt == '0);
  assign busy       = (state != IDLE);

  llr_loader #(
    .WIDTH(WIDTH),
    .N_V  (N_V),
    .LANES(LANES)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .first   (state == IDLE),
    .in_llr  (in_llr),
    .all_llrs(all_llrs),
    .last    (last)
  );

  always_comb begin
    state_nx = state;
    iter_nx  = iter_cnt;
    ls_nx    = 1'b0;
    os_nx    = 1'b0;
    dw_nx    = dw_out;
    dv_nx    = dw_valid;
    unique case (state)
      IDLE, LOAD: begin
        if (xfer && last) begin
          state_nx = VAR;
          iter_nx  = '0;
          ls_nx    = 1'b1;
        end else if (xfer) begin
          state_nx = LOAD;
        end
      end
      VAR: begin
        if (layer_done) begin
          state_nx = CHK;
          ls_nx    = 1'b1;
        end
      end
      CHK: begin
        if (layer_done) begin
          if (iter_cnt == IW'(N_ITER - 1)) begin
            state_nx = OUT;
            os_nx    = 1'b1;
          end else begin
            state_nx = VAR;
            iter_nx  = iter_cnt + 1'b1;
            ls_nx    = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_done) begin
          state_nx = DONE;
          dw_nx    = dw_in;
          dv_nx    = 1'b1;
        end
      end
      DONE: begin
        if (dw_ack) begin
          state_nx = IDLE;
          dv_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      layer_start <= 1'b0;
      out_start   <= 1'b0;
      dw_out      <= '0;
      dw_valid    <= 1'b0;
    end else begin
      state       <= state_nx;
      iter_cnt    <= iter_nx;
      layer_start <= ls_nx;
      out_start   <= os_nx;
      dw_out      <= dw_nx;
      dw_valid    <= dv_nx;
    end
  end

endmodule
